falafel_alloc_walker: RTL and testbench

//  First-fit allocator engine, directly upstream of falafel_lsu. Accepts malloc-size requests,

---
 rtl/falafel_alloc_walker.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_falafel_alloc_walker.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/falafel_alloc_walker.sv
// -----------------------------------------------------------------------------
// falafel_alloc_walker
//   First-fit allocator engine sitting directly upstream of falafel_lsu.
//   Accepts a malloc size, takes the global free-list lock, walks the singly
//   linked free list and unlinks the first block that fits. It returns the
//   payload pointer, or NULL_PTR on failure. Every memory access is one LSU op
//   (ISSUE state, then WAIT state).
//
//   Build option: FALAFEL_SPLIT_EN -- when defined, a fitting block with at
//   least 2*WORD_SIZE bytes to spare is split, and the tail stays on the free
//   list. When undefined, the whole block is taken and its size word is left
//   untouched.
//
//   Ports
//     clk_i, rst_ni          clock, synchronous active-low reset
//     alloc_req_*            size request (val/rdy/size), accepted only in IDLE
//     alloc_rsp_*            result (val/rdy/ptr), ptr held until consumed
//     lsu_req_*              LSU op channel (val/rdy/op/addr/word/lock_id/block)
//     lsu_rsp_*              LSU completion (val/rdy/word/block)
// -----------------------------------------------------------------------------
package falafel_alloc_walker_pkg;
    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] WORD_SIZE = 32'd4;
    localparam logic [DATA_W-1:0] NULL_PTR  = 32'd0;

    typedef enum logic [2:0] {
        LSU_OP_NONE        = 3'd0,
        LSU_OP_LOCK        = 3'd1,
        LSU_OP_UNLOCK      = 3'd2,
        LSU_OP_LOAD_WORD   = 3'd3,
        LSU_OP_LOAD_BLOCK  = 3'd4,
        LSU_OP_STORE_WORD  = 3'd5,
        LSU_OP_STORE_BLOCK = 3'd6
    } lsu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] size;
        logic [DATA_W-1:0] next_ptr;
    } free_block_t;
endpackage

module falafel_alloc_walker
    import falafel_alloc_walker_pkg::*;
#(
    parameter logic [DATA_W-1:0] HEAD_ADDR = 32'h100,
    parameter logic [DATA_W-1:0] LOCK_ADDR = 32'h0,
    parameter logic [DATA_W-1:0] LOCK_ID   = 32'h1,
    parameter logic [DATA_W-1:0] MAX_WALK  = 32'd64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alloc_req_val_i,
    output logic              alloc_req_rdy_o,
    input  logic [DATA_W-1:0] alloc_req_size_i,
    output logic              alloc_rsp_val_o,
    input  logic              alloc_rsp_rdy_i,
    output logic [DATA_W-1:0] alloc_rsp_ptr_o,
    output logic              lsu_req_val_o,
    input  logic              lsu_req_rdy_i,
    output lsu_op_e           lsu_req_op_o,
    output logic [DATA_W-1:0] lsu_req_addr_o,
    output logic [DATA_W-1:0] lsu_req_word_o,
    output logic [DATA_W-1:0] lsu_req_lock_id_o,
    output free_block_t       lsu_req_block_o,
    input  logic              lsu_rsp_val_i,
    output logic              lsu_rsp_rdy_o,
    input  logic [DATA_W-1:0] lsu_rsp_word_i,
    input  free_block_t       lsu_rsp_block_i
);

    localparam logic [4:0] S_IDLE      = 5'd0;
    localparam logic [4:0] S_LOCK_ISS  = 5'd1;
    localparam logic [4:0] S_LOCK_WAIT = 5'd2;
    localparam logic [4:0] S_HEAD_ISS  = 5'd3;
    localparam logic [4:0] S_HEAD_WAIT = 5'd4;
    localparam logic [4:0] S_CHECK     = 5'd5;
    localparam logic [4:0] S_BLK_ISS   = 5'd6;
    localparam logic [4:0] S_BLK_WAIT  = 5'd7;
    localparam logic [4:0] S_LINK_ISS  = 5'd8;
    localparam logic [4:0] S_LINK_WAIT = 5'd9;
    localparam logic [4:0] S_UNLK_ISS  = 5'd10;
    localparam logic [4:0] S_UNLK_WAIT = 5'd11;
    localparam logic [4:0] S_RESPOND   = 5'd12;
`ifdef FALAFEL_SPLIT_EN
    localparam logic [4:0] S_SPLB_ISS  = 5'd13;
    localparam logic [4:0] S_SPLB_WAIT = 5'd14;
    localparam logic [4:0] S_SPLS_ISS  = 5'd15;
    localparam logic [4:0] S_SPLS_WAIT = 5'd16;
`endif

    logic [4:0]        state_q, state_d;
    logic [DATA_W-1:0] need_q, need_d;     // rounded payload + header bytes
    logic [DATA_W-1:0] cur_q, cur_d;       // block under inspection
    logic [DATA_W-1:0] link_q, link_d;     // word that points at cur
    logic [DATA_W-1:0] walk_q, walk_d;     // blocks inspected so far
    logic [DATA_W-1:0] next_q, next_d;     // value to store through link
    logic [DATA_W-1:0] result_q, result_d;
`ifdef FALAFEL_SPLIT_EN
    logic [DATA_W-1:0] blk_size_q, blk_size_d;
`endif

    assign lsu_req_lock_id_o = LOCK_ID;

    always_comb begin
        state_d  = state_q;
        need_d   = need_q;
        cur_d    = cur_q;
        link_d   = link_q;
        walk_d   = walk_q;
        next_d   = next_q;
        result_d = result_q;
`ifdef FALAFEL_SPLIT_EN
        blk_size_d = blk_size_q;
`endif
        alloc_req_rdy_o = 1'b0;
        alloc_rsp_val_o = 1'b0;
        alloc_rsp_ptr_o = '0;
        lsu_req_val_o   = 1'b0;
        lsu_req_op_o    = LSU_OP_NONE;
        lsu_req_addr_o  = '0;
        lsu_req_word_o  = '0;
        lsu_req_block_o = '0;
        lsu_rsp_rdy_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                alloc_req_rdy_o = 1'b1;
                if (alloc_req_val_i) begin
                    need_d   = ((alloc_req_size_i + WORD_SIZE - 32'd1) & ~(WORD_SIZE - 32'd1))
                               + WORD_SIZE;
                    result_d = NULL_PTR;
                    // A zero-byte request never touches memory.
                    state_d  = (alloc_req_size_i == '0) ? S_RESPOND : S_LOCK_ISS;
                end
            end
            S_LOCK_ISS: begin
                lsu_req_val_o  = 1'b1;
                lsu_req_op_o   = LSU_OP_LOCK;
                lsu_req_addr_o = LOCK_ADDR;
                if (lsu_req_rdy_i) state_d = S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                lsu_rsp_rdy_o = 1'b1;
                if (lsu_rsp_val_i) state_d = S_HEAD_ISS;
            end
            S_HEAD_ISS: begin
                lsu_req_val_o  = 1'b1;
                lsu_req_op_o   = LSU_OP_LOAD_WORD;
                lsu_req_addr_o = HEAD_ADDR;
                if (lsu_req_rdy_i) state_d = S_HEAD_WAIT;
            end
            S_HEAD_WAIT: begin
                lsu_rsp_rdy_o = 1'b1;
                if (lsu_rsp_val_i) begin
                    cur_d   = lsu_rsp_word_i;
                    link_d  = HEAD_ADDR;
                    walk_d  = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cur_q == NULL_PTR || walk_q == MAX_WALK) begin
                    result_d = NULL_PTR;
                    state_d  = S_UNLK_ISS;
                end else begin
                    walk_d  = walk_q + 32'd1;
                    state_d = S_BLK_ISS;
                end
            end
            S_BLK_ISS: begin
                lsu_req_val_o  = 1'b1;
                lsu_req_op_o   = LSU_OP_LOAD_BLOCK;
                lsu_req_addr_o = cur_q;
                if (lsu_req_rdy_i) state_d = S_BLK_WAIT;
            end
            S_BLK_WAIT: begin
                lsu_rsp_rdy_o = 1'b1;
                if (lsu_rsp_val_i) begin
                    if (lsu_rsp_block_i.size >= need_q) begin
                        next_d   = lsu_rsp_block_i.next_ptr;
                        result_d = cur_q + WORD_SIZE;
`ifdef FALAFEL_SPLIT_EN
                        blk_size_d = lsu_rsp_block_i.size;
                        state_d    = (lsu_rsp_block_i.size - need_q >= (WORD_SIZE << 1))
                                     ? S_SPLB_ISS : S_LINK_ISS;
`else
                        state_d  = S_LINK_ISS;
`endif
                    end else begin
                        // next_ptr lives one word into the block we just skipped.
                        link_d  = cur_q + WORD_SIZE;
                        cur_d   = lsu_rsp_block_i.next_ptr;
                        state_d = S_CHECK;
                    end
                end
            end
`ifdef FALAFEL_SPLIT_EN
            S_SPLB_ISS: begin
                lsu_req_val_o            = 1'b1;
                lsu_req_op_o             = LSU_OP_STORE_BLOCK;
                lsu_req_addr_o           = cur_q + need_q;
                lsu_req_block_o.size     = blk_size_q - need_q;
                lsu_req_block_o.next_ptr = next_q;
                if (lsu_req_rdy_i) state_d = S_SPLB_WAIT;
            end
            S_SPLB_WAIT: begin
                lsu_rsp_rdy_o = 1'b1;
                if (lsu_rsp_val_i) state_d = S_SPLS_ISS;
            end
            S_SPLS_ISS: begin
                lsu_req_val_o  = 1'b1;
                lsu_req_op_o   = LSU_OP_STORE_WORD;
                lsu_req_addr_o = cur_q;
                lsu_req_word_o = need_q;
                if (lsu_req_rdy_i) state_d = S_SPLS_WAIT;
            end
            S_SPLS_WAIT: begin
                lsu_rsp_rdy_o = 1'b1;
                if (lsu_rsp_val_i) begin
                    // The link now points at the remainder instead of the old successor.
                    next_d  = cur_q + need_q;
                    state_d = S_LINK_ISS;
                end
            end
`endif
            S_LINK_ISS: begin
                lsu_req_val_o  = 1'b1;
                lsu_req_op_o   = LSU_OP_STORE_WORD;
                lsu_req_addr_o = link_q;
                lsu_req_word_o = next_q;
                if (lsu_req_rdy_i) state_d = S_LINK_WAIT;
            end
            S_LINK_WAIT: begin
                lsu_rsp_rdy_o = 1'b1;
                if (lsu_rsp_val_i) state_d = S_UNLK_ISS;
            end
            S_UNLK_ISS: begin
                lsu_req_val_o  = 1'b1;
                lsu_req_op_o   = LSU_OP_UNLOCK;
                lsu_req_addr_o = LOCK_ADDR;
                if (lsu_req_rdy_i) state_d = S_UNLK_WAIT;
            end
            S_UNLK_WAIT: begin
                lsu_rsp_rdy_o = 1'b1;
                if (lsu_rsp_val_i) state_d = S_RESPOND;
            end
            S_RESPOND: begin
                alloc_rsp_val_o = 1'b1;
                alloc_rsp_ptr_o = result_q;
                if (alloc_rsp_rdy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            need_q   <= '0;
            cur_q    <= NULL_PTR;
            link_q   <= NULL_PTR;
            walk_q   <= '0;
            next_q   <= NULL_PTR;
            result_q <= NULL_PTR;
`ifdef FALAFEL_SPLIT_EN
            blk_size_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            need_q   <= need_d;
            cur_q    <= cur_d;
            link_q   <= link_d;
            walk_q   <= walk_d;
            next_q   <= next_d;
            result_q <= result_d;
`ifdef FALAFEL_SPLIT_EN
            blk_size_q <= blk_size_d;
`endif
        end
    end

endmodule

// File: tb/tb_falafel_alloc_walker.sv
// -----------------------------------------------------------------------------
// tb_falafel_alloc_walker
//   Directed bench for falafel_alloc_walker. Two instances share the stimulus:
//   dut_a uses MAX_WALK=64, dut_b uses MAX_WALK=1; sel_b picks the active one.
//   A small LSU model serves word-addressed memory and logs every accepted op.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_falafel_alloc_walker;
    import falafel_alloc_walker_pkg::*;

    localparam logic [31:0] TB_LOCK_ID = 32'h1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        alloc_req_val;
    logic [31:0] alloc_req_size;
    logic        alloc_rsp_rdy;
    logic        lsu_req_rdy;
    logic        lsu_rsp_val;
    logic [31:0] lsu_rsp_word;
    free_block_t lsu_rsp_block;
    logic        sel_b;

    logic a_req_rdy, b_req_rdy, a_rsp_val, b_rsp_val, a_lval, b_lval, a_rrdy, b_rrdy;
    logic [31:0] a_ptr, b_ptr, a_addr, b_addr, a_word, b_word, a_lid, b_lid;
    lsu_op_e     a_op, b_op;
    free_block_t a_blk, b_blk;

    logic        req_rdy, rsp_val, lval, rrdy;
    logic [31:0] rsp_ptr, addr, word, lid;
    logic [2:0]  op;
    free_block_t blk;

    assign req_rdy = sel_b ? b_req_rdy : a_req_rdy;
    assign rsp_val = sel_b ? b_rsp_val : a_rsp_val;
    assign rsp_ptr = sel_b ? b_ptr     : a_ptr;
    assign lval    = sel_b ? b_lval    : a_lval;
    assign rrdy    = sel_b ? b_rrdy    : a_rrdy;
    assign addr    = sel_b ? b_addr    : a_addr;
    assign word    = sel_b ? b_word    : a_word;
    assign lid     = sel_b ? b_lid     : a_lid;
    assign op      = sel_b ? 3'(b_op)  : 3'(a_op);
    assign blk     = sel_b ? b_blk     : a_blk;

    falafel_alloc_walker #(.MAX_WALK(32'd64)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .alloc_req_val_i(alloc_req_val & ~sel_b), .alloc_req_rdy_o(a_req_rdy),
        .alloc_req_size_i(alloc_req_size),
        .alloc_rsp_val_o(a_rsp_val), .alloc_rsp_rdy_i(alloc_rsp_rdy & ~sel_b),
        .alloc_rsp_ptr_o(a_ptr),
        .lsu_req_val_o(a_lval), .lsu_req_rdy_i(lsu_req_rdy & ~sel_b),
        .lsu_req_op_o(a_op), .lsu_req_addr_o(a_addr), .lsu_req_word_o(a_word),
        .lsu_req_lock_id_o(a_lid), .lsu_req_block_o(a_blk),
        .lsu_rsp_val_i(lsu_rsp_val & ~sel_b), .lsu_rsp_rdy_o(a_rrdy),
        .lsu_rsp_word_i(lsu_rsp_word), .lsu_rsp_block_i(lsu_rsp_block)
    );

    falafel_alloc_walker #(.MAX_WALK(32'd1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .alloc_req_val_i(alloc_req_val & sel_b), .alloc_req_rdy_o(b_req_rdy),
        .alloc_req_size_i(alloc_req_size),
        .alloc_rsp_val_o(b_rsp_val), .alloc_rsp_rdy_i(alloc_rsp_rdy & sel_b),
        .alloc_rsp_ptr_o(b_ptr),
        .lsu_req_val_o(b_lval), .lsu_req_rdy_i(lsu_req_rdy & sel_b),
        .lsu_req_op_o(b_op), .lsu_req_addr_o(b_addr), .lsu_req_word_o(b_word),
        .lsu_req_lock_id_o(b_lid), .lsu_req_block_o(b_blk),
        .lsu_rsp_val_i(lsu_rsp_val & sel_b), .lsu_rsp_rdy_o(b_rrdy),
        .lsu_rsp_word_i(lsu_rsp_word), .lsu_rsp_block_i(lsu_rsp_block)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory + LSU model ----------------
    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] word;
        free_block_t blk;
    } op_rec_t;

    logic [31:0] mem [0:255];
    op_rec_t     log_q[$];
    op_rec_t     exp_q[$];
    int          stall_n = 0;
    bit          hold_blk = 1'b0;

    task automatic init_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'h200;
        mem[32'h200 >> 2] = 32'd16;
        mem[32'h204 >> 2] = 32'h300;
        mem[32'h300 >> 2] = 32'd64;
        mem[32'h304 >> 2] = 32'h0;
    endtask

    task automatic serve(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                         input free_block_t b);
        op_rec_t r;
        logic [7:0] idx;
        r.op = o; r.addr = a; r.word = w; r.blk = b;
        log_q.push_back(r);
        idx = a[9:2];
        lsu_rsp_word  = 32'h0;
        lsu_rsp_block = '0;
        case (o)
            LSU_OP_LOCK:        mem[idx] = TB_LOCK_ID;
            LSU_OP_UNLOCK:      mem[idx] = 32'h0;
            LSU_OP_LOAD_WORD:   lsu_rsp_word = mem[idx];
            LSU_OP_LOAD_BLOCK: begin
                lsu_rsp_block.size     = mem[idx];
                lsu_rsp_block.next_ptr = mem[idx + 8'd1];
            end
            LSU_OP_STORE_WORD:  mem[idx] = w;
            LSU_OP_STORE_BLOCK: begin
                mem[idx]        = b.size;
                mem[idx + 8'd1] = b.next_ptr;
            end
            default: ;
        endcase
    endtask

    initial begin : lsu_model
        bit          stalling;
        logic [2:0]  hold_op;
        logic [31:0] hold_addr;
        stalling = 1'b0; hold_op = '0; hold_addr = '0;
        lsu_req_rdy = 1'b0; lsu_rsp_val = 1'b0;
        lsu_rsp_word = 32'h0; lsu_rsp_block = '0;
        forever begin
            @(negedge clk);
            lsu_rsp_val = 1'b0;
            lsu_req_rdy = 1'b0;
            if (rst_n && lval && !(hold_blk && op == LSU_OP_LOAD_BLOCK)) begin
                if (stall_n > 0) begin
                    if (!stalling) begin
                        stalling  = 1'b1;
                        hold_op   = op;
                        hold_addr = addr;
                    end else begin
                        check_eq("stall_op", op, hold_op);
                        check_eq("stall_addr", addr, hold_addr);
                    end
                    stall_n--;
                end else begin
                    stalling    = 1'b0;
                    lsu_req_rdy = 1'b1;
                    serve(op, addr, word, blk);
                    @(negedge clk);
                    lsu_req_rdy = 1'b0;
                    check_eq("wait_rsp_rdy", rrdy, 1);
                    lsu_rsp_val = 1'b1;
                end
            end
        end
    end

    // ---------------- expected op sequences ----------------
    task automatic expect_op(input lsu_op_e o, input logic [31:0] a, input logic [31:0] w,
                             input logic [31:0] bs, input logic [31:0] bn);
        op_rec_t r;
        r.op = o; r.addr = a; r.word = w; r.blk.size = bs; r.blk.next_ptr = bn;
        exp_q.push_back(r);
    endtask

    task automatic check_log(input string name);
        int n;
        check_eq($sformatf("%s_nops", name), log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_op%0d", name, i), log_q[i].op, exp_q[i].op);
            check_eq($sformatf("%s_addr%0d", name, i), log_q[i].addr, exp_q[i].addr);
            if (exp_q[i].op == LSU_OP_STORE_WORD)
                check_eq($sformatf("%s_word%0d", name, i), log_q[i].word, exp_q[i].word);
            if (exp_q[i].op == LSU_OP_STORE_BLOCK)
                check_eq($sformatf("%s_blk%0d", name, i), log_q[i].blk, exp_q[i].blk);
        end
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        check_eq({name, "_req_rdy"}, req_rdy, 1);
        check_eq({name, "_rsp_val"}, rsp_val, 0);
        check_eq({name, "_rsp_ptr"}, rsp_ptr, 0);
        check_eq({name, "_lsu_val"}, lval, 0);
        check_eq({name, "_lsu_op"}, op, 0);
        check_eq({name, "_lsu_addr"}, addr, 0);
        check_eq({name, "_lsu_word"}, word, 0);
        check_eq({name, "_lsu_blk"}, blk, 0);
        check_eq({name, "_lsu_rsp_rdy"}, rrdy, 0);
        check_eq({name, "_lock_id"}, lid, TB_LOCK_ID);
    endtask

    task automatic do_alloc(input logic [31:0] sz, input int rsp_hold,
                            output logic [31:0] ptr, output int lat);
        int n;
        log_q.delete();
        @(negedge clk);
        n = 0;
        while (!req_rdy && n < 50) begin @(negedge clk); n++; end
        check_eq("accept_ready", req_rdy, 1);
        alloc_req_val  = 1'b1;
        alloc_req_size = sz;
        @(negedge clk);
        alloc_req_val  = 1'b0;
        alloc_req_size = 32'hDEAD_BEEF;   // must be ignored after accept
        lat = 1;
        while (!rsp_val && lat < 500) begin @(negedge clk); lat++; end
        check_eq("rsp_timeout", rsp_val, 1);
        ptr = rsp_ptr;
        for (int i = 0; i < rsp_hold; i++) begin
            @(negedge clk);
            check_eq("rsp_hold_val", rsp_val, 1);
            check_eq("rsp_hold_ptr", rsp_ptr, ptr);
        end
        alloc_rsp_rdy = 1'b1;
        @(negedge clk);
        alloc_rsp_rdy = 1'b0;
        check_eq("back_to_idle", req_rdy, 1);
        $display("alloc size=%0d dut=%s -> ptr=0x%0h lsu_ops=%0d latency=%0d",
                 sz, sel_b ? "b" : "a", ptr, log_q.size(), lat);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] ptr;
        int          lat;
        int          n;

        rst_n = 1'b0; alloc_req_val = 1'b0; alloc_req_size = 32'h0;
        alloc_rsp_rdy = 1'b0; sel_b = 1'b0;
        init_mem();
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");

        // alloc 20 (need 24): skips 0x200, takes 0x300; LSU stalls 5 cycles, rsp held 3.
        stall_n = 5;
        do_alloc(32'd20, 3, ptr, lat);
        check_eq("a20_ptr", ptr, 32'h304);
        expect_op(LSU_OP_LOCK,       32'h0,   0, 0, 0);
        expect_op(LSU_OP_LOAD_WORD,  32'h100, 0, 0, 0);
        expect_op(LSU_OP_LOAD_BLOCK, 32'h200, 0, 0, 0);
        expect_op(LSU_OP_LOAD_BLOCK, 32'h300, 0, 0, 0);
`ifdef FALAFEL_SPLIT_EN
        expect_op(LSU_OP_STORE_BLOCK, 32'h318, 0, 32'd40, 32'h0);
        expect_op(LSU_OP_STORE_WORD,  32'h300, 32'd24, 0, 0);
        expect_op(LSU_OP_STORE_WORD,  32'h204, 32'h318, 0, 0);
`else
        expect_op(LSU_OP_STORE_WORD, 32'h204, 32'h0, 0, 0);
`endif
        expect_op(LSU_OP_UNLOCK,     32'h0,   0, 0, 0);
        check_log("a20");
`ifdef FALAFEL_SPLIT_EN
        check_eq("a20_mem204", mem[32'h204 >> 2], 32'h318);
        check_eq("a20_mem300", mem[32'h300 >> 2], 32'd24);
        check_eq("a20_mem318", mem[32'h318 >> 2], 32'd40);
`else
        check_eq("a20_mem204", mem[32'h204 >> 2], 32'h0);
        check_eq("a20_mem300", mem[32'h300 >> 2], 32'd64);
`endif
        check_eq("a20_lock", mem[0], 32'h0);

        // alloc 12: exact fit at 0x200, head relinked, never split.
        init_mem();
        do_alloc(32'd12, 0, ptr, lat);
        check_eq("a12_ptr", ptr, 32'h204);
        expect_op(LSU_OP_LOCK,       32'h0,   0, 0, 0);
        expect_op(LSU_OP_LOAD_WORD,  32'h100, 0, 0, 0);
        expect_op(LSU_OP_LOAD_BLOCK, 32'h200, 0, 0, 0);
        expect_op(LSU_OP_STORE_WORD, 32'h100, 32'h300, 0, 0);
        expect_op(LSU_OP_UNLOCK,     32'h0,   0, 0, 0);
        check_log("a12");
        check_eq("a12_head", mem[32'h100 >> 2], 32'h300);
        check_eq("a12_size", mem[32'h200 >> 2], 32'd16);
        check_eq("a12_lock", mem[0], 32'h0);

        // alloc 100: walks both blocks, fails, lock still released.
        init_mem();
        do_alloc(32'd100, 0, ptr, lat);
        check_eq("a100_ptr", ptr, 32'h0);
        expect_op(LSU_OP_LOCK,       32'h0,   0, 0, 0);
        expect_op(LSU_OP_LOAD_WORD,  32'h100, 0, 0, 0);
        expect_op(LSU_OP_LOAD_BLOCK, 32'h200, 0, 0, 0);
        expect_op(LSU_OP_LOAD_BLOCK, 32'h300, 0, 0, 0);
        expect_op(LSU_OP_UNLOCK,     32'h0,   0, 0, 0);
        check_log("a100");
        check_eq("a100_lock", mem[0], 32'h0);
        check_eq("a100_head", mem[32'h100 >> 2], 32'h200);

        // alloc 0: immediate NULL response, no LSU traffic.
        do_alloc(32'd0, 0, ptr, lat);
        check_eq("a0_ptr", ptr, 32'h0);
        check_eq("a0_latency", lat, 1);
        check_log("a0");

        // MAX_WALK=1 instance: alloc 20 gives up after one block.
        sel_b = 1'b1;
        init_mem();
        do_alloc(32'd20, 0, ptr, lat);
        check_eq("mw1_ptr", ptr, 32'h0);
        expect_op(LSU_OP_LOCK,       32'h0,   0, 0, 0);
        expect_op(LSU_OP_LOAD_WORD,  32'h100, 0, 0, 0);
        expect_op(LSU_OP_LOAD_BLOCK, 32'h200, 0, 0, 0);
        expect_op(LSU_OP_UNLOCK,     32'h0,   0, 0, 0);
        check_log("mw1");
        check_eq("mw1_lock", mem[0], 32'h0);
        sel_b = 1'b0;

        // Reset while LOAD_BLOCK is pending: back to IDLE, lock word left taken.
        init_mem();
        hold_blk = 1'b1;
        log_q.delete();
        @(negedge clk);
        alloc_req_val  = 1'b1;
        alloc_req_size = 32'd20;
        @(negedge clk);
        alloc_req_val  = 1'b0;
        n = 0;
        while (!(lval && op == LSU_OP_LOAD_BLOCK) && n < 100) begin @(negedge clk); n++; end
        check_eq("rst_reach_ldblk", lval && op == LSU_OP_LOAD_BLOCK, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        rst_n    = 1'b1;
        hold_blk = 1'b0;
        check_eq("rst_lock_kept", mem[0], TB_LOCK_ID);
        $display("reset during LOAD_BLOCK -> outputs idle, lock word=0x%0h", mem[0]);

        // Recovery after the system clears the lock.
        init_mem();
        do_alloc(32'd12, 0, ptr, lat);
        check_eq("recover_ptr", ptr, 32'h204);
        exp_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
